// File: rtl/biriscv_defs.sv
// Shared definitions for the biriscv instruction-fetch path.
//
// Contents:
//   req_id_e     - identifies which requester owns an in-flight icache read
//                  (demand fetch or prefetch)
//   arb_state_e  - grant state of the icache arbiter (open or locked)
//   ICACHE_ARB_MAX_OUTSTANDING / _W - default in-flight read depth and its log2
package biriscv_defs;

    typedef enum logic {
        REQ_ID_DEMAND   = 1'b0,
        REQ_ID_PREFETCH = 1'b1
    } req_id_e;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int ICACHE_ARB_MAX_OUTSTANDING   = 2;
    localparam int ICACHE_ARB_MAX_OUTSTANDING_W = 1;

endpackage

// File: rtl/biriscv_icache_arb_if.sv
// Instruction-cache bus between the fetch arbiter and the icache.
//
// Signals:
//   icache_rd_o / icache_pc_o / icache_priv_o  - read request (arbiter -> icache)
//   icache_accept_i                            - request taken (icache -> arbiter)
//   icache_valid_i / icache_inst_i /
//   icache_error_i / icache_page_fault_i       - in-order response (icache -> arbiter)
//
// Modports:
//   master - the arbiter side
//   slave  - the icache side
interface biriscv_icache_arb_if;

    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [63:0] icache_inst_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;

    modport master (
        output icache_rd_o,
        output icache_pc_o,
        output icache_priv_o,
        input  icache_accept_i,
        input  icache_valid_i,
        input  icache_inst_i,
        input  icache_error_i,
        input  icache_page_fault_i
    );

    modport slave (
        input  icache_rd_o,
        input  icache_pc_o,
        input  icache_priv_o,
        output icache_accept_i,
        output icache_valid_i,
        output icache_inst_i,
        output icache_error_i,
        output icache_page_fault_i
    );

endinterface

// File: rtl/biriscv_icache_arb_idfifo.sv
// Requester-ID FIFO for the icache arbiter. Records, in issue order, which
// requester owns each in-flight icache read so in-order responses can be
// steered back to the right requester.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears pointers/count)
//   push      - write push_id at the tail
//   push_id   - requester ID of the accepted read
//   pop       - retire the head entry
//   head_id   - ID at the head (owner of the next response)
//   count     - number of entries held (0..DEPTH)
//
// DEPTH must be a power of two so the pointers wrap on their own.
module biriscv_icache_arb_idfifo
    import biriscv_defs::*;
#(
    parameter int DEPTH   = ICACHE_ARB_MAX_OUTSTANDING,
    parameter int DEPTH_W = ICACHE_ARB_MAX_OUTSTANDING_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  req_id_e          push_id,
    input  logic             pop,
    output req_id_e          head_id,
    output logic [DEPTH_W:0] count
);

    req_id_e              mem [DEPTH];
    logic [DEPTH_W-1:0]   wr_ptr;
    logic [DEPTH_W-1:0]   rd_ptr;

    // Storage carries no reset; entries are only read once pointed at by a
    // valid count, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Push and pop may coincide even when full: the head is read before the
    // tail slot (the same slot) is overwritten at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_W'(1);
            end
            count <= count + (DEPTH_W + 1)'(push) - (DEPTH_W + 1)'(pop);
        end
    end

    assign head_id = mem[rd_ptr];

endmodule

// File: rtl/biriscv_icache_arb.sv
// Two-requester instruction-cache arbiter. Merges the demand-fetch port (req0)
// and the prefetch port (req1) onto one icache bus, keeps up to
// MAX_OUTSTANDING reads in flight, and steers the in-order responses back to
// the owner with zero latency. A flush discards every read still in flight.
//
// Ports:
//   clk_i, rst_i               - clock, synchronous active-high reset
//   req0_* / req1_*            - demand / prefetch requesters: rd, pc, priv in;
//                                accept (taken this cycle) and valid (response) out
//   resp_inst_o/_error_o/
//   resp_page_fault_o          - response payload shared by both requesters
//   flush_i                    - drop all in-flight responses, block issue
//   icache                     - icache bus (master modport)
//   busy_o                     - reads in flight
//   proto_err_o                - sticky: response arrived with nothing in flight
//
// Build option:
//   BIRISCV_ICACHE_ARB_RR_EN   - round-robin arbitration instead of req0-first
module biriscv_icache_arb
    import biriscv_defs::*;
#(
    parameter int MAX_OUTSTANDING   = ICACHE_ARB_MAX_OUTSTANDING,
    parameter int MAX_OUTSTANDING_W = ICACHE_ARB_MAX_OUTSTANDING_W
)
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_rd_i,
    input  logic [31:0]          req0_pc_i,
    input  logic [1:0]           req0_priv_i,
    output logic                 req0_accept_o,
    output logic                 req0_valid_o,
    input  logic                 req1_rd_i,
    input  logic [31:0]          req1_pc_i,
    input  logic [1:0]           req1_priv_i,
    output logic                 req1_accept_o,
    output logic                 req1_valid_o,
    output logic [63:0]          resp_inst_o,
    output logic                 resp_error_o,
    output logic                 resp_page_fault_o,
    input  logic                 flush_i,
    biriscv_icache_arb_if.master icache,
    output logic                 busy_o,
    output logic                 proto_err_o
);

    localparam int              CNT_W   = MAX_OUTSTANDING_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    arb_state_e        state_q;
    arb_state_e        state_d;
    req_id_e           lock_id_q;
    req_id_e           lock_id_d;
    req_id_e           grant_id;
    req_id_e           head_id;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  discard_q;
    logic [CNT_W-1:0]  discard_d;
    logic              can_issue;
    logic              rd_issue;
    logic              accept;
    logic              resp_take;
    logic              resp_drop;
    logic              proto_err_q;

`ifdef BIRISCV_ICACHE_ARB_RR_EN
    logic              rr_ptr_q;
`endif

    // Issue is held off during reset so nothing is accepted and then lost.
    assign can_issue = !rst_i && !flush_i && (count < CNT_MAX);

    // Grant lock state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_OPEN;
            lock_id_q <= REQ_ID_DEMAND;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Grant selection and lock control. A request left hanging (issued, not
    // accepted) keeps its grant so the icache sees a stable address; flush
    // blocks issue, which releases the lock.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        grant_id  = REQ_ID_DEMAND;

        case (state_q)
            ARB_LOCKED: begin
                grant_id = lock_id_q;
            end
            default: begin
`ifdef BIRISCV_ICACHE_ARB_RR_EN
                if (rr_ptr_q) begin
                    grant_id = (req1_rd_i || !req0_rd_i) ? REQ_ID_PREFETCH : REQ_ID_DEMAND;
                end else begin
                    grant_id = (req0_rd_i || !req1_rd_i) ? REQ_ID_DEMAND : REQ_ID_PREFETCH;
                end
`else
                grant_id = (req0_rd_i || !req1_rd_i) ? REQ_ID_DEMAND : REQ_ID_PREFETCH;
`endif
            end
        endcase

        rd_issue = can_issue &&
                   ((grant_id == REQ_ID_PREFETCH) ? req1_rd_i : req0_rd_i);
        accept   = rd_issue && icache.icache_accept_i;

        if (rd_issue && !icache.icache_accept_i) begin
            state_d   = ARB_LOCKED;
            lock_id_d = grant_id;
        end else begin
            state_d   = ARB_OPEN;
        end
    end

    assign icache.icache_rd_o   = rd_issue;
    assign icache.icache_pc_o   = (grant_id == REQ_ID_PREFETCH) ? req1_pc_i   : req0_pc_i;
    assign icache.icache_priv_o = (grant_id == REQ_ID_PREFETCH) ? req1_priv_i : req0_priv_i;
    assign req0_accept_o        = accept && (grant_id == REQ_ID_DEMAND);
    assign req1_accept_o        = accept && (grant_id == REQ_ID_PREFETCH);

`ifdef BIRISCV_ICACHE_ARB_RR_EN
    // After each accept the other requester gets first call.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= 1'b0;
        end else if (accept) begin
            rr_ptr_q <= (grant_id == REQ_ID_DEMAND);
        end
    end
`endif

    biriscv_icache_arb_idfifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .DEPTH_W (MAX_OUTSTANDING_W)
    ) u_idfifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (accept),
        .push_id (grant_id),
        .pop     (resp_take),
        .head_id (head_id),
        .count   (count)
    );

    // A response with nothing in flight is ignored entirely (no pop).
    // Responses owed to a flushed read, or arriving with the flush itself,
    // are consumed silently.
    assign resp_take    = icache.icache_valid_i && (count != '0);
    assign resp_drop    = flush_i || (discard_q != '0);
    assign req0_valid_o = resp_take && !resp_drop && (head_id == REQ_ID_DEMAND);
    assign req1_valid_o = resp_take && !resp_drop && (head_id == REQ_ID_PREFETCH);

    assign resp_inst_o       = icache.icache_inst_i;
    assign resp_error_o      = icache.icache_error_i;
    assign resp_page_fault_o = icache.icache_page_fault_i;

    // On flush every read still in flight becomes a discard; a response
    // retired in the flush cycle already counts against that total.
    always_comb begin
        discard_d = discard_q;
        if (flush_i) begin
            discard_d = count + CNT_W'(accept) - CNT_W'(resp_take);
        end else if (resp_take && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    // Discard counter and sticky protocol-error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            discard_q <= discard_d;
            if (icache.icache_valid_i && (count == '0)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign busy_o      = (count != '0);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_biriscv_icache_arb.sv
// Self-checking bench for biriscv_icache_arb. Random requesters and a random
// icache model drive the arbiter; a scoreboard queue of expected responses
// is filled on every expected accept and drained by a separate monitor that
// checks response routing, payload and flush discards.
module tb_biriscv_icache_arb;

    localparam int MAX_OUT = 2;

    typedef struct {
        bit          id;
        logic [63:0] inst;
        bit          err;
        bit          pf;
        bit          drop;
    } exp_t;

    typedef struct {
        logic [63:0] inst;
        bit          err;
        bit          pf;
    } ic_t;

    logic        clk;
    logic        rst;
    logic        req0_rd, req1_rd;
    logic [31:0] req0_pc, req1_pc;
    logic [1:0]  req0_priv, req1_priv;
    logic        req0_accept, req1_accept;
    logic        req0_valid, req1_valid;
    logic [63:0] resp_inst;
    logic        resp_error, resp_page_fault;
    logic        flush;
    logic        busy, proto_err;

    biriscv_icache_arb_if icache_bus ();

    biriscv_icache_arb #(
        .MAX_OUTSTANDING   (MAX_OUT),
        .MAX_OUTSTANDING_W (1)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req0_rd_i         (req0_rd),
        .req0_pc_i         (req0_pc),
        .req0_priv_i       (req0_priv),
        .req0_accept_o     (req0_accept),
        .req0_valid_o      (req0_valid),
        .req1_rd_i         (req1_rd),
        .req1_pc_i         (req1_pc),
        .req1_priv_i       (req1_priv),
        .req1_accept_o     (req1_accept),
        .req1_valid_o      (req1_valid),
        .resp_inst_o       (resp_inst),
        .resp_error_o      (resp_error),
        .resp_page_fault_o (resp_page_fault),
        .flush_i           (flush),
        .icache            (icache_bus),
        .busy_o            (busy),
        .proto_err_o       (proto_err)
    );

    exp_t        exp_q [$];
    ic_t         ic_q [$];
    bit          pend_valid [2];
    logic [31:0] pend_pc [2];
    logic [1:0]  pend_priv [2];
    bit          lock_valid;
    bit          lock_id;
    bit          rr_pref;
    bit          proto_exp;
    bit          resp_from_ic;
    bit          exp_issue;
    bit          exp_gid;
    int          checks;
    int          failures;
    exp_t        mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected arbiter outputs from the requester/icache rules: a hanging
    // request keeps its grant, otherwise the preferred requester wins.
    task automatic checkOutput();
        if (lock_valid) begin
            exp_gid = lock_id;
        end else if (rr_pref) begin
            exp_gid = pend_valid[1] ? 1'b1 : 1'b0;
        end else begin
            exp_gid = pend_valid[0] ? 1'b0 : 1'b1;
        end
        exp_issue = !rst && !flush && (exp_q.size() < MAX_OUT) && pend_valid[exp_gid];

        compare("icache_rd", 64'(icache_bus.icache_rd_o), 64'(exp_issue));
        if (exp_issue) begin
            compare("icache_pc", 64'(icache_bus.icache_pc_o), 64'(pend_pc[exp_gid]));
            compare("icache_priv", 64'(icache_bus.icache_priv_o), 64'(pend_priv[exp_gid]));
        end
        compare("req0_accept", 64'(req0_accept),
                64'(exp_issue && icache_bus.icache_accept_i && exp_gid == 1'b0));
        compare("req1_accept", 64'(req1_accept),
                64'(exp_issue && icache_bus.icache_accept_i && exp_gid == 1'b1));
        compare("busy", 64'(busy), 64'(exp_q.size() != 0));
        compare("proto_err", 64'(proto_err), 64'(proto_exp));
    endtask

    // One clock of stimulus: inputs change on the falling edge, outputs are
    // checked 1ns later, and the reference model advances on the rising edge.
    task automatic applyStimulus(input bit allow_req, input bit allow_resp,
                                 input bit allow_flush, input bit spurious,
                                 input bit do_reset);
        ic_t  r;
        exp_t e;
        @(negedge clk);
        rst = do_reset;
        for (int n = 0; n < 2; n++) begin
            if (!pend_valid[n] && allow_req && $urandom_range(0, 2) == 0) begin
                pend_valid[n] = 1'b1;
                pend_pc[n]    = $urandom() & 32'hFFFF_FFFC;
                pend_priv[n]  = 2'($urandom_range(0, 3));
            end
        end
        req0_rd   = pend_valid[0];
        req0_pc   = pend_pc[0];
        req0_priv = pend_priv[0];
        req1_rd   = pend_valid[1];
        req1_pc   = pend_pc[1];
        req1_priv = pend_priv[1];
        icache_bus.icache_accept_i     = ($urandom_range(0, 3) != 0);
        flush                          = allow_flush && !do_reset && ($urandom_range(0, 31) == 0);
        resp_from_ic                   = 1'b0;
        icache_bus.icache_valid_i      = 1'b0;
        icache_bus.icache_inst_i       = {$urandom(), $urandom()};
        icache_bus.icache_error_i      = 1'b0;
        icache_bus.icache_page_fault_i = 1'b0;
        if (!do_reset) begin
            if (spurious) begin
                icache_bus.icache_valid_i = 1'b1;
            end else if (allow_resp && ic_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                icache_bus.icache_valid_i      = 1'b1;
                icache_bus.icache_inst_i       = ic_q[0].inst;
                icache_bus.icache_error_i      = ic_q[0].err;
                icache_bus.icache_page_fault_i = ic_q[0].pf;
                resp_from_ic                   = 1'b1;
            end
        end
        #1;
        checkOutput();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            lock_valid = 1'b0;
            rr_pref    = 1'b0;
            proto_exp  = 1'b0;
        end else begin
            if (exp_issue && icache_bus.icache_accept_i) begin
                r.inst = {$urandom(), $urandom()};
                r.err  = ($urandom_range(0, 7) == 0);
                r.pf   = ($urandom_range(0, 7) == 0);
                ic_q.push_back(r);
                e.id   = exp_gid;
                e.inst = r.inst;
                e.err  = r.err;
                e.pf   = r.pf;
                e.drop = 1'b0;
                exp_q.push_back(e);
                pend_valid[exp_gid] = 1'b0;
`ifdef BIRISCV_ICACHE_ARB_RR_EN
                rr_pref = !exp_gid;
`endif
            end
            lock_valid = exp_issue && !icache_bus.icache_accept_i;
            lock_id    = exp_gid;
        end
        if (resp_from_ic) begin
            void'(ic_q.pop_front());
        end
    endtask

    // Scoreboard monitor: a flush turns every in-flight read into a discard;
    // each icache response retires the oldest expected entry and must appear
    // on its owner's valid (or nowhere, if discarded or nothing was in flight).
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (flush) begin
                foreach (exp_q[i]) exp_q[i].drop = 1'b1;
            end
            if (icache_bus.icache_valid_i) begin
                if (exp_q.size() == 0) begin
                    compare("orphan_req0_valid", 64'(req0_valid), 64'd0);
                    compare("orphan_req1_valid", 64'(req1_valid), 64'd0);
                    proto_exp = 1'b1;
                end else begin
                    mon_e = exp_q.pop_front();
                    compare("req0_valid", 64'(req0_valid), 64'(!mon_e.drop && mon_e.id == 1'b0));
                    compare("req1_valid", 64'(req1_valid), 64'(!mon_e.drop && mon_e.id == 1'b1));
                    if (!mon_e.drop) begin
                        compare("resp_inst", resp_inst, mon_e.inst);
                        compare("resp_error", 64'(resp_error), 64'(mon_e.err));
                        compare("resp_page_fault", 64'(resp_page_fault), 64'(mon_e.pf));
                    end
                end
            end else if (req0_valid || req1_valid) begin
                compare("valid_without_response", 64'({req1_valid, req0_valid}), 64'd0);
            end
        end
    end

    initial begin
        int guard;
        checks     = 0;
        failures   = 0;
        lock_valid = 1'b0;
        lock_id    = 1'b0;
        rr_pref    = 1'b0;
        proto_exp  = 1'b0;
        pend_valid = '{1'b0, 1'b0};
        pend_pc    = '{32'd0, 32'd0};
        pend_priv  = '{2'd0, 2'd0};
        rst        = 1'b1;
        flush      = 1'b0;
        req0_rd    = 1'b0;
        req1_rd    = 1'b0;
        req0_pc    = '0;
        req1_pc    = '0;
        req0_priv  = '0;
        req1_priv  = '0;
        icache_bus.icache_accept_i     = 1'b0;
        icache_bus.icache_valid_i      = 1'b0;
        icache_bus.icache_inst_i       = '0;
        icache_bus.icache_error_i      = 1'b0;
        icache_bus.icache_page_fault_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then idle with outputs quiet.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        repeat (3000) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Drain everything still pending or in flight.
        guard = 0;
        while ((ic_q.size() > 0 || pend_valid[0] || pend_valid[1]) && guard < 500) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        compare("drain_timeout", 64'(guard >= 500), 64'd0);

        // Response with nothing in flight: ignored, sticky error until reset.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with reads in flight: idle afterwards, late responses are orphans.
        guard = 0;
        while (exp_q.size() < MAX_OUT && guard < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        compare("fill_timeout", 64'(guard >= 200), 64'd0);
        pend_valid = '{1'b0, 1'b0};
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (ic_q.size() > 0 && guard < 100) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        compare("late_resp_timeout", 64'(guard >= 100), 64'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/biriscv_icache_arb.md
BIRISCV_ICACHE_ARB -- requirements
Module: biriscv_icache_arb

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning in-flight icache read depth (power of two, 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING_W, default 1, meaning log2(MAX_OUTSTANDING).
REQ-003 SHALL have ports:
 clk_i  in  1  clock, all state on rising edge
 rst_i  in  1  reset, synchronous, active-high
 req0_rd_i  in  1  demand-fetch read request
 req0_pc_i  in  32  demand-fetch address
 req0_priv_i  in  2  demand-fetch privilege
 req0_accept_o  out  1  demand request accepted this cycle
 req0_valid_o  out  1  demand response valid
 req1_rd_i / req1_pc_i / req1_priv_i / req1_accept_o / req1_valid_o  as req0, prefetch requester
 resp_inst_o  out  64  response data, shared by both requesters
 resp_error_o  out  1  bus error on response
 resp_page_fault_o  out  1  page fault on response
 flush_i  in  1  discard all in-flight responses
 icache_rd_o  out  1  icache read request
 icache_pc_o  out  32  icache address
 icache_priv_o  out  2  icache privilege
 icache_accept_i  in  1  icache accepted request
 icache_valid_i  in  1  icache response valid
 icache_inst_i  in  64  icache response data
 icache_error_i  in  1  icache bus error
 icache_page_fault_i  in  1  icache page fault
 busy_o  out  1  outstanding count non-zero
 proto_err_o  out  1  sticky: response received with nothing outstanding

Function
REQ-004 SHALL issue icache_rd_o only when outstanding count < MAX_OUTSTANDING and a requester asserts rd.
REQ-005 SHALL drive icache_pc_o/icache_priv_o combinationally from the granted requester; reqN_accept_o = grant N AND icache_accept_i.
REQ-006 SHALL lock the grant while icache_rd_o is high and icache_accept_i low; lock releases on accept or flush_i.
REQ-007 SHALL arbitrate fixed priority, req0 over req1, unless REQ-017 applies.
REQ-008 SHALL push the granted requester ID into an ID FIFO on each accept; count increments.
REQ-009 SHALL route icache_valid_i to req0_valid_o or req1_valid_o per FIFO head ID, same cycle (zero latency), and pop the head.
REQ-010 SHALL pass icache_inst_i/error/page_fault to resp_* unregistered.
REQ-011 On flush_i SHALL set discard counter = outstanding count (plus any accept in the same cycle); responses while discard > 0 SHALL be popped with both reqN_valid_o low, decrementing discard.
REQ-012 Response and flush in the same cycle: response SHALL be dropped and counted against the discard total.
REQ-013 Accept and response in the same cycle SHALL leave count unchanged; push and pop both occur, including when full.
REQ-014 Response with count 0 SHALL be ignored and set proto_err_o until reset.
REQ-015 No request SHALL issue in the cycle flush_i is high.

Reset
REQ-016 On rst_i SHALL clear FIFO pointers, count, discard counter, lock, RR pointer and proto_err_o; all outputs 0 the cycle after reset.

Configuration
REQ-017 With BIRISCV_ICACHE_ARB_RR_EN defined, arbitration SHALL be round-robin: pointer toggles to the other requester after each accept. Without it, fixed priority per REQ-007.

Structure
REQ-018 Requester ID encoding and MAX_OUTSTANDING default SHALL live in the shared biriscv_defs package.
REQ-019 The ID FIFO SHALL be a sub-module, biriscv_icache_arb_idfifo.

Verification
REQ-020 req0 and req1 both rd, icache_accept_i=1 -> req0_accept_o=1, icache_pc_o=req0_pc_i; with RR_EN, next cycle req1 granted.
REQ-021 Two accepts (IDs 1,0), no response -> icache_rd_o=0 while full; responses return -> req1_valid_o then req0_valid_o.
REQ-022 req1 granted, icache_accept_i=0 for 3 cycles, req0 rises -> icache_pc_o stays req1_pc_i until accept.
REQ-023 Two outstanding, flush_i pulse -> next two responses produce no reqN_valid_o; third response routed normally.
REQ-024 icache_valid_i with count 0 -> no valid out, proto_err_o=1 until rst_i.
REQ-025 rst_i asserted with two outstanding -> busy_o=0 next cycle; late response sets proto_err_o.
